// File: rtl/logic_gate_pipe_if.sv
// Streaming bus for logic_gate_pipe: operand side (a/b/op) and result side (c, flags, counter).
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; the
// producer holds its payload stable while valid=1 and ready=0, and ready never depends on valid.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             red_and;
  logic             red_or;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, red_and, red_or, done_cnt
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, red_and, red_or, done_cnt
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise logic unit: eight ops on two WIDTH-bit operands, STAGES-deep
// register chain with a single global advance enable, reduction flags and a result counter.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  logic_gate_pipe_if.slave  bus
);
  localparam int DW = WIDTH + 2;

  logic [WIDTH-1:0] res;
  logic [DW-1:0]    res_pack;
  logic             adv;
  logic [STAGES-1:0] vld;
  logic [DW-1:0]     dat [STAGES];
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    res = '0;
    case (bus.op)
      3'd0: res = bus.a & bus.b;
      3'd1: res = bus.a | bus.b;
      3'd2: res = bus.a ^ bus.b;
      3'd3: res = ~(bus.a & bus.b);
      3'd4: res = ~(bus.a | bus.b);
      3'd5: res = ~(bus.a ^ bus.b);
      3'd6: res = ~bus.a;
      3'd7: res = bus.a;
      default: res = '0;
    endcase
  end

  // Flags ride with the result so they stay aligned through every stage.
  assign res_pack = {&res, |res, res};

  // Whole pipe moves together; an empty output slot lets it advance even when stalled.
  assign adv          = bus.out_ready | ~vld[STAGES-1];
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      if (bus.in_valid) dat[0] <= res_pack;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (vld[STAGES-1] && bus.out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.c         = dat[STAGES-1][WIDTH-1:0];
  assign bus.red_or    = dat[STAGES-1][WIDTH];
  assign bus.red_and   = dat[STAGES-1][WIDTH+1];
  assign bus.done_cnt  = cnt;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: 8-bit/2-stage/3-bit-counter instance with a
// scoreboard queue, plus a 1-bit/1-stage instance for the full truth table.
module tb_logic_gate_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(3))  bus ();
  logic_gate_pipe_if #(.WIDTH(1), .CNT_W(16)) tt ();

  logic_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic_gate_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut_tt (
    .clk (clk),
    .rst (rst),
    .bus (tt)
  );

  logic [9:0] exp_q[$];
  logic [2:0] exp_cnt = '0;
  int n_checks = 0;
  int n_fail   = 0;

  // bit i of each entry is the expected result for {a,b} = i
  logic [3:0] tt_exp [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                             4'b0001, 4'b1001, 4'b0011, 4'b1100};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic [2:0] opv);
    logic [7:0] r;
    case (opv)
      3'd0: r = av & bv;
      3'd1: r = av | bv;
      3'd2: r = av ^ bv;
      3'd3: r = ~(av & bv);
      3'd4: r = ~(av | bv);
      3'd5: r = ~(av ^ bv);
      3'd6: r = ~av;
      default: r = av;
    endcase
    return {(r == 8'hFF), (r != 8'h00), r};
  endfunction

  // Scoreboard monitor: pops on every output transfer, tracks the wrapping count.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_cnt", bus.done_cnt, exp_cnt);
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("sb_data", {bus.red_and, bus.red_or, bus.c}, exp_q.pop_front());
        exp_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] opv);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.op = opv;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        exp_q.push_back(model(av, bv, opv));
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] cv,
                            input logic ra, input logic ro);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_c"}, bus.c, cv);
    check({tag, "_flags"}, {bus.red_and, bus.red_or}, {ra, ro});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    tt.in_valid = 1'b0;  tt.a = '0;  tt.b = '0;  tt.op = '0;  tt.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_c", bus.c, 0);
    check("rst_flags", {bus.red_and, bus.red_or}, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // latency: visible in the cycle after edge N+1
    send(8'hF0, 8'h3C, 3'd2);
    @(negedge clk);
    check("lat_early", bus.out_valid, 0);
    @(negedge clk);
    check("lat_valid", bus.out_valid, 1);
    check("lat_c", bus.c, 8'hCC);
    check("lat_flags", {bus.red_and, bus.red_or}, 2'b01);
    @(posedge clk);
    #1;

    // back-pressure
    do_reset();
    send(8'h12, 8'h34, 3'd2);
    send(8'h56, 8'h0F, 3'd2);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h9A; bus.b = 8'hFF; bus.op = 3'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_c_stable", bus.c, 8'h26);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(8'h9A, 8'hFF, 3'd2);
    send(8'hC3, 8'h81, 3'd2);
    drain();
    @(negedge clk);
    check("bp_done_cnt", bus.done_cnt, 4);
    @(posedge clk);
    #1;

    // reductions
    send(8'hFF, 8'hFF, 3'd0);
    expect_out("red_and_op", 8'hFF, 1'b1, 1'b1);
    send(8'hFF, 8'hFF, 3'd4);
    expect_out("red_nor_op", 8'h00, 1'b0, 1'b0);

    // reset mid-stream
    send(8'hAA, 8'hFF, 3'd0);
    send(8'h0F, 8'hF0, 3'd1);
    do_reset();
    @(negedge clk);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_c", bus.c, 0);
    check("mid_done_cnt", bus.done_cnt, 0);
    @(posedge clk);
    #1;
    send(8'h3C, 8'h0F, 3'd0);
    expect_out("post_rst", 8'h0C, 1'b0, 1'b1);

    // counter wrap with a 3-bit counter
    do_reset();
    for (int k = 0; k < 9; k++) send(8'(k * 37), 8'(k * 11 + 5), 3'(k));
    drain();
    @(negedge clk);
    check("wrap_final", bus.done_cnt, 1);
    @(posedge clk);
    #1;

    // full truth table on the 1-bit, single-stage instance
    for (int k = 0; k <= 32; k++) begin
      int pk;
      if (k < 32) begin
        tt.in_valid = 1'b1; tt.op = k[4:2]; tt.a = k[1]; tt.b = k[0];
      end else begin
        tt.in_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        pk = k - 1;
        check("tt_valid", tt.out_valid, 1);
        check("tt_c", tt.c, tt_exp[pk[4:2]][pk[1:0]]);
        check("tt_flags", {tt.red_and, tt.red_or}, {2{tt_exp[pk[4:2]][pk[1:0]]}});
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the single 2-input AND gate.
- Applies one of eight bitwise logic operations to two WIDTH-bit operands.
- Carries the result through a STAGES-deep registered pipeline with valid/ready handshaking on both sides.
- Also produces per-result reduction flags and a wrapping count of completed results, so benches and upstream logic can use it as a streaming logic unit.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- STAGES, 2, pipeline depth = input-to-output latency in cycles (>=1).
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  a, b, op valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select, sampled with a/b.
- out_valid  output  1  c, red_and, red_or valid.
- out_ready  input  1  downstream accepts output this cycle.
- c  output  WIDTH  result.
- red_and  output  1  AND-reduction of c.
- red_or  output  1  OR-reduction of c.
- done_cnt  output  CNT_W  number of output transfers since reset, wraps.

Behaviour:
- Op encoding:
  - 000 AND: a&b.
  - 001 OR.
  - 010 XOR.
  - 011 NAND.
  - 100 NOR.
  - 101 XNOR.
  - 110 NOT a (b ignored).
  - 111 PASS a.
- Result computed combinationally from the inputs and registered into stage 1. Stages 2..STAGES are plain registers, each holding {valid, c}.
- red_and and red_or are computed in stage 1 alongside c and travel with it.
- Advance rule: global enable adv = out_ready | ~out_valid.
  - When adv=1, every stage shifts one step. Stage 1 loads in_valid&in_ready, with data when valid.
  - When adv=0, all stages hold.
- in_ready = adv (combinational from out_ready and out_valid). No combinational path from in_valid to in_ready.
- Input transfer: in_valid & in_ready on a rising edge.
- Output transfer: out_valid & out_ready on a rising edge.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. in the cycle following it, provided no stall occurs.
- Throughput: 1 result/cycle while out_ready stays high.
- Bubbles: invalid stages shift like valid ones. Bubbles are not collapsed.
- Ordering: results leave in acceptance order. No result is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, c, red_and and red_or must stay constant.
- done_cnt:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
  - Registered output.
- Reset (rst=1 at a rising edge):
  - Clears all stage valids, so out_valid=0.
  - c=0, red_and=0, red_or=0, done_cnt=0.
  - in_ready reads 1 from the first cycle after reset.
- Reset mid-stream flushes in-flight results. They are never presented.
- Reset dominates a simultaneous input or output transfer: nothing is accepted and the counter does not increment.
- Simultaneous input and output transfer in the same cycle is legal and does not stall.
- in_valid=0 with in_ready=1 injects a bubble. a, b and op are don't-care.

Test Plan:
- Truth table, WIDTH=1, STAGES=1, out_ready=1:
  - Stimulus: each op over (a,b) in {00,01,10,11}.
  - AND gives 0,0,0,1; NAND gives 1,1,1,0; the other ops match their encodings.
  - Each result appears 1 cycle after acceptance.
- Latency, WIDTH=8, STAGES=2, out_ready=1:
  - Stimulus: a=8'hF0, b=8'h3C, op=010.
  - c=8'hCC with out_valid=1 exactly 2 edges after acceptance; red_and=0, red_or=1.
- Back-pressure, STAGES=2:
  - Stimulus: stream 4 XOR operations; hold out_ready=0 for 3 cycles once out_valid=1.
  - in_ready=0 during the stall; c is stable.
  - All 4 results emerge in order, none lost; done_cnt=4.
- Reductions:
  - a=8'hFF, b=8'hFF, op=000 gives c=8'hFF, red_and=1, red_or=1.
  - op=100 with the same operands gives c=0, red_and=0, red_or=0.
- Reset mid-stream:
  - Stimulus: 2 operations in flight, then assert rst for 1 cycle.
  - out_valid=0, c=0 and done_cnt=0 after the edge; flushed results never appear.
  - The next accepted operation returns normally.
- Counter wrap, CNT_W=3:
  - Stimulus: 9 output transfers.
  - done_cnt goes 1..7, 0, 1.
